alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one combinational 64-bit ALU between NREQ requesters (fetch-side address adder, execute stage, branch unit). Each request is one operation: operands A/B plus a 3-bit cntrl code. The block picks a requester by round-robin, drives the ALU from registered operands for one full cycle, and captures result and flags. It then returns them on a single tagged response channel with valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 64, operand/result width; must match the ALU.
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ), requester-id width (derived).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*WIDTH  operand A, slice i for requester i.
- req_b  in  NREQ*WIDTH  operand B.
- req_cntrl  in  NREQ*3  operation code.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester that owns the response.
- rsp_result  out  WIDTH  ALU result.
- rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out  out  1 each  flags.
- rsp_err  out  1  illegal cntrl code.
- alu_a, alu_b  out  WIDTH  registered ALU operands.
- alu_cntrl  out  3  registered ALU control.
- alu_result  in  WIDTH  ALU result (combinational from alu_*).
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags.

## Operation
- Legal cntrl values: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor. Values 001 and 111 are illegal.
- FSM states are IDLE, EXEC and RESP.
- IDLE: the round-robin grant is computed over req_valid. req_ready[g] = req_valid[g] for the granted g; all other ready bits are 0. On the handshake, latch A, B, cntrl and id, then go to EXEC.
- Illegal cntrl: latch alu_cntrl=000 and a pending error bit. The op still goes through EXEC.
- EXEC: alu_* are stable for the whole cycle. At the end of the cycle, capture alu_result and the flags into the rsp registers, then go to RESP.
- Flag masking: for cntrl not in {010, 011}, capture overflow and carry_out as 0.
- Error capture: for an illegal op, result=0, zero=1, negative=0, overflow=0, carry_out=0, rsp_err=1.
- RESP: rsp_valid=1. All rsp_* are held stable until rsp_ready=1, then go to IDLE.
- Round-robin: the pointer points at the last granted id. Search starts at pointer+1 and wraps modulo NREQ. The pointer updates only on a request handshake.
- Requesters must hold valid and operands stable until ready. Dropping valid before ready is permitted; that requester is simply not granted.

## Timing
- Reset values: state=IDLE, rr pointer=NREQ-1 (requester 0 wins first), req_ready=0, rsp_valid=0, rsp_* =0, alu_a=alu_b=0, alu_cntrl=000.
- Request handshake at edge t means EXEC in cycle t+1 and rsp_valid=1 in cycle t+2.
- With rsp_ready held high, the response completes at edge t+2, IDLE follows in t+3, and the next handshake can occur at edge t+3. Peak throughput is 1 op per 3 cycles.
- rsp_ready low stalls in RESP indefinitely. No new request is accepted (all req_ready=0).
- Simultaneous valids from all requesters: exactly one ready bit, following round-robin order.
- Reset asserted mid-operation: immediate return to reset values. The in-flight op is dropped and no response is issued.
- req_ready is combinational from req_valid and state. There is no combinational path from rsp_ready to req_ready.

## Structure
- Shared package alu_pkg:
  - cntrl constants ALU_PASS_B, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR;
  - function alu_cntrl_legal();
  - state enum typedef alu_arb_state_t.
- Sub-module rr_arbiter (NREQ): inputs req, advance; outputs one-hot grant and grant id; owns the pointer. It is reusable for the register-file port arbiter.
- The ALU itself is not instantiated here. The bench wraps the block with the real ALU.

## Test plan
- Single add, requester 0: A=5, B=7, cntrl=010 -> rsp_valid 2 cycles after handshake; result=12, id=0, zero=0, carry_out=0, overflow=0.
- Sub with overflow, requester 1: A=0x8000_0000_0000_0000, B=1, cntrl=011 -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1, negative=0, carry_out=1.
- Both requesters valid continuously, rsp_ready=1, 6 ops -> grant order 0,1,0,1,0,1; one handshake every 3 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_* stable; req_ready=0 throughout; released on the first rsp_ready cycle.
- Illegal cntrl=111 with A=3, B=4 -> rsp_err=1, result=0, zero=1, and the ALU sees cntrl 000; xor 0xF0^0xFF -> 0x0F with overflow/carry_out=0 even if the ALU drives 1.
- Assert reset_n=0 during EXEC -> no rsp_valid afterwards; all outputs at reset values; the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: ALU control codes, code
// classification helpers and the arbiter FSM state type.
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } alu_arb_state_t;

    function automatic logic alu_cntrl_legal(input logic [2:0] cntrl);
        return (cntrl == ALU_PASS_B) || (cntrl == ALU_ADD) || (cntrl == ALU_SUB) ||
               (cntrl == ALU_AND)    || (cntrl == ALU_OR)  || (cntrl == ALU_XOR);
    endfunction

    // Only add and sub produce meaningful overflow / carry_out.
    function automatic logic alu_cntrl_arith(input logic [2:0] cntrl);
        return (cntrl == ALU_ADD) || (cntrl == ALU_SUB);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the pointer holds the last granted id and the search
// starts one past it, wrapping modulo NREQ. The pointer moves only on advance.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_valid
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that skips an assignment infers a latch.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDW'((int'(ptr) + off) % NREQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= IDW'(NREQ - 1);
        end else if (advance && grant_valid) begin
            ptr <= grant_id;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between NREQ requesters: round-robin
// grant, one registered EXEC cycle, then a held tagged response.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREQ  = 2,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_cntrl,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_negative,
    output logic                  rsp_zero,
    output logic                  rsp_overflow,
    output logic                  rsp_carry_out,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_cntrl,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_negative,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    input  logic                  alu_carry_out
);

    alu_arb_state_t state, state_next;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic             grant_valid;
    logic             req_fire;
    logic [IDW-1:0]   id_q;
    logic             err_q;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_cntrl;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req_valid),
        .advance     (req_fire),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Ready depends only on state and req_valid, never on rsp_ready.
    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign req_fire  = (state == ST_IDLE) && grant_valid;
    assign rsp_valid = (state == ST_RESP);

    assign sel_a     = req_a[int'(grant_id)*WIDTH +: WIDTH];
    assign sel_b     = req_b[int'(grant_id)*WIDTH +: WIDTH];
    assign sel_cntrl = req_cntrl[int'(grant_id)*3 +: 3];

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_fire)  state_next = ST_EXEC;
            ST_EXEC:                state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Illegal codes still occupy the ALU for a cycle, driven as a harmless pass-B.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cntrl <= ALU_PASS_B;
            id_q      <= '0;
            err_q     <= 1'b0;
        end else if (req_fire) begin
            alu_a <= sel_a;
            alu_b <= sel_b;
            id_q  <= grant_id;
            if (alu_cntrl_legal(sel_cntrl)) begin
                alu_cntrl <= sel_cntrl;
                err_q     <= 1'b0;
            end else begin
                alu_cntrl <= ALU_PASS_B;
                err_q     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_id        <= '0;
            rsp_result    <= '0;
            rsp_negative  <= 1'b0;
            rsp_zero      <= 1'b0;
            rsp_overflow  <= 1'b0;
            rsp_carry_out <= 1'b0;
            rsp_err       <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_id <= id_q;
            if (err_q) begin
                rsp_result    <= '0;
                rsp_negative  <= 1'b0;
                rsp_zero      <= 1'b1;
                rsp_overflow  <= 1'b0;
                rsp_carry_out <= 1'b0;
                rsp_err       <= 1'b1;
            end else begin
                rsp_result    <= alu_result;
                rsp_negative  <= alu_negative;
                rsp_zero      <= alu_zero;
                rsp_overflow  <= alu_cntrl_arith(alu_cntrl) && alu_overflow;
                rsp_carry_out <= alu_cntrl_arith(alu_cntrl) && alu_carry_out;
                rsp_err       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: wraps it with a behavioural 64-bit ALU, applies
// a vector table plus round-robin, backpressure and mid-op reset sequences.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int W = 64;
    localparam int N = 2;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*3-1:0] req_cntrl;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [0:0]     rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err;
    logic [W-1:0]   alu_a, alu_b, alu_result;
    logic [2:0]     alu_cntrl;
    logic           alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic           force_fl;
    logic [W:0]     wide;

    alu_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_cntrl     (req_cntrl),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_negative  (rsp_negative),
        .rsp_zero      (rsp_zero),
        .rsp_overflow  (rsp_overflow),
        .rsp_carry_out (rsp_carry_out),
        .rsp_err       (rsp_err),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_cntrl     (alu_cntrl),
        .alu_result    (alu_result),
        .alu_negative  (alu_negative),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .alu_carry_out (alu_carry_out)
    );

    // Behavioural ALU; force_fl makes it drive overflow/carry_out high.
    always_comb begin
        wide          = '0;
        alu_result    = '0;
        alu_overflow  = 1'b0;
        alu_carry_out = 1'b0;
        case (alu_cntrl)
            ALU_PASS_B: alu_result = alu_b;
            ALU_ADD: begin
                wide          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result    = wide[W-1:0];
                alu_carry_out = wide[W];
                alu_overflow  = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            ALU_SUB: begin
                wide          = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
                alu_result    = wide[W-1:0];
                alu_carry_out = wide[W];
                alu_overflow  = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_XOR: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
        alu_negative = alu_result[W-1];
        alu_zero     = (alu_result == '0);
        if (force_fl) begin
            alu_overflow  = 1'b1;
            alu_carry_out = 1'b1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         rq;
        logic [63:0] a, b;
        logic [2:0] cntrl;
        logic       force_fl;
        logic [63:0] e_res;
        logic       e_neg, e_zero, e_ov, e_co, e_err;
        logic [2:0] e_alu_cntrl;
    } vec_t;

    typedef struct {
        int         id;
        logic [63:0] res;
        logic       neg, zero, ov, co, err;
        int         hs_cyc;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   cyc = 0;
    exp_t exp_next[N];
    exp_t sb[$];
    int   grant_log[$];
    int   hs_log[$];
    logic prev_valid;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string name, input int rq, input logic [63:0] a,
                                input logic [63:0] b, input logic [2:0] cntrl, input logic ff,
                                input logic [63:0] res, input logic neg, input logic zero,
                                input logic ov, input logic co, input logic err,
                                input logic [2:0] acn);
        vec_t v;
        v.name = name; v.rq = rq; v.a = a; v.b = b; v.cntrl = cntrl; v.force_fl = ff;
        v.e_res = res; v.e_neg = neg; v.e_zero = zero; v.e_ov = ov; v.e_co = co;
        v.e_err = err; v.e_alu_cntrl = acn;
        return v;
    endfunction

    function automatic exp_t mk_exp(input int id, input logic [63:0] res, input logic neg,
                                    input logic zero, input logic ov, input logic co,
                                    input logic err);
        exp_t e;
        e.id = id; e.res = res; e.neg = neg; e.zero = zero; e.ov = ov; e.co = co;
        e.err = err; e.hs_cyc = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: pushes on request handshake, pops on response handshake.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if ($countones(req_valid) > 1)
                check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    e = exp_next[i];
                    e.hs_cyc = cyc;
                    sb.push_back(e);
                    grant_log.push_back(i);
                    hs_log.push_back(cyc);
                end
            end
            if (rsp_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_rsp: rsp_valid with nothing outstanding (t=%0t)", $time);
                end else begin
                    check("latency", 64'(cyc - sb[0].hs_cyc), 64'd2);
                end
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id",        64'(rsp_id),        64'(e.id));
                check("rsp_result",    rsp_result,         e.res);
                check("rsp_negative",  64'(rsp_negative),  64'(e.neg));
                check("rsp_zero",      64'(rsp_zero),      64'(e.zero));
                check("rsp_overflow",  64'(rsp_overflow),  64'(e.ov));
                check("rsp_carry_out", 64'(rsp_carry_out), 64'(e.co));
                check("rsp_err",       64'(rsp_err),       64'(e.err));
                n_done++;
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic drive_op(input int r, input logic [63:0] a, input logic [63:0] b,
                            input logic [2:0] c, input exp_t e);
        req_a[r*W +: W]   = a;
        req_b[r*W +: W]   = b;
        req_cntrl[r*3 +: 3] = c;
        exp_next[r]       = e;
        req_valid[r]      = 1'b1;
    endtask

    task automatic set_add(input int r, input int k);
        logic [63:0] a;
        a = 64'(1000 * k + 10 * r + 1);
        drive_op(r, a, 64'd3, ALU_ADD, mk_exp(r, a + 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic wait_done(input string name, input int target);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #2;
            if (n_done >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    task automatic wait_ready(input int r, output logic got);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   base;
        logic got;
        base = n_done;
        @(posedge clk); #1;
        force_fl = v.force_fl;
        drive_op(v.rq, v.a, v.b, v.cntrl,
                 mk_exp(v.rq, v.e_res, v.e_neg, v.e_zero, v.e_ov, v.e_co, v.e_err));
        wait_ready(v.rq, got);
        check({v.name, "_handshake"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        if (got) begin
            check({v.name, "_alu_cntrl"}, 64'(alu_cntrl), 64'(v.e_alu_cntrl));
            check({v.name, "_alu_a"},     alu_a,          v.a);
        end
        wait_done({v.name, "_done"}, base + 1);
        force_fl = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   cnt[N];
        int   nhs;
        logic got;

        vecs[0] = mk("add_5_7",  0, 64'd5, 64'd7, ALU_ADD, 1'b0, 64'd12, 0, 0, 0, 0, 0, ALU_ADD);
        vecs[1] = mk("sub_ovf",  1, 64'h8000_0000_0000_0000, 64'd1, ALU_SUB, 1'b0,
                     64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1, 0, ALU_SUB);
        vecs[2] = mk("illegal7", 0, 64'd3, 64'd4, 3'b111, 1'b0, 64'd0, 0, 1, 0, 0, 1, ALU_PASS_B);
        vecs[3] = mk("xor_mask", 1, 64'hF0, 64'hFF, ALU_XOR, 1'b1, 64'h0F, 0, 0, 0, 0, 0, ALU_XOR);
        vecs[4] = mk("passb_0",  0, 64'd9, 64'd0, ALU_PASS_B, 1'b0, 64'd0, 0, 1, 0, 0, 0, ALU_PASS_B);
        vecs[5] = mk("and",      1, 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00, ALU_AND, 1'b0,
                     64'hFF00_0000_FF00_0000, 1, 0, 0, 0, 0, ALU_AND);
        vecs[6] = mk("or",       0, 64'd1, 64'h8000_0000_0000_0000, ALU_OR, 1'b0,
                     64'h8000_0000_0000_0001, 1, 0, 0, 0, 0, ALU_OR);
        vecs[7] = mk("add_wrap", 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 1'b0,
                     64'd0, 0, 1, 0, 1, 0, ALU_ADD);
        vecs[8] = mk("sub_brw",  0, 64'd5, 64'd7, ALU_SUB, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0, 0, ALU_SUB);
        vecs[9] = mk("add_ovf",  1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 1'b0,
                     64'h8000_0000_0000_0000, 1, 0, 1, 0, 0, ALU_ADD);

        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cntrl = '0;
        rsp_ready = 1'b1;
        force_fl  = 1'b0;
        #12;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_alu_a",     alu_a,          64'd0);
        check("rst_alu_cntrl", 64'(alu_cntrl), 64'd0);
        check("rst_rsp_result", rsp_result,    64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Both requesters valid continuously: grants alternate, one every 3 cycles.
        grant_log.delete();
        hs_log.delete();
        base = n_done;
        cnt[0] = 0;
        cnt[1] = 0;
        nhs = 0;
        @(posedge clk); #1;
        set_add(0, 0);
        set_add(1, 0);
        for (int c = 0; c < 60 && nhs < 6; c++) begin
            @(negedge clk);
            if (|(req_ready & req_valid)) begin
                int g;
                g = req_ready[1] ? 1 : 0;
                nhs++;
                @(posedge clk); #1;
                cnt[g]++;
                set_add(g, cnt[g]);
            end
        end
        req_valid = '0;
        check("rr_handshakes", 64'(nhs), 64'd6);
        wait_done("rr_done", base + 6);
        check("rr_log_size", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < grant_log.size() && i < 6; i++) begin
            check("rr_grant_order", 64'(grant_log[i]), 64'(i % 2));
            if (i > 0) check("rr_spacing", 64'(hs_log[i] - hs_log[i-1]), 64'd3);
        end

        // Backpressure: response held for 5 cycles with new requests waiting.
        base = n_done;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        force_fl  = 1'b1;
        drive_op(0, 64'd7, 64'd8, 3'b001, mk_exp(0, 64'd0, 0, 1, 0, 0, 1));
        wait_ready(0, got);
        check("bp_handshake", 64'(got), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("bp_rsp_seen", 64'(got), 64'd1);
        @(posedge clk); #1;
        set_add(0, 7);
        set_add(1, 7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid",  64'(rsp_valid), 64'd1);
            check("bp_req_ready",  64'(req_ready), 64'd0);
            check("bp_rsp_result", rsp_result,     64'd0);
            check("bp_rsp_err",    64'(rsp_err),   64'd1);
            check("bp_rsp_zero",   64'(rsp_zero),  64'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        force_fl  = 1'b0;
        @(posedge clk); #1;
        check("bp_released",  64'(rsp_valid), 64'd0);
        check("bp_next_grant", 64'(req_ready), 64'b10);
        @(posedge clk); #1;
        req_valid = '0;
        wait_done("bp_done", base + 2);

        // Reset during EXEC drops the op; pointer returns so requester 0 wins.
        base = n_done;
        @(posedge clk); #1;
        drive_op(0, 64'd1, 64'd1, ALU_ADD, mk_exp(0, 64'd2, 0, 0, 0, 0, 0));
        wait_ready(0, got);
        check("rst_mid_handshake", 64'(got), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        reset_n   = 1'b0;
        #1;
        sb.delete();
        check("rstm_rsp_valid",  64'(rsp_valid), 64'd0);
        check("rstm_req_ready",  64'(req_ready), 64'd0);
        check("rstm_alu_a",      alu_a,          64'd0);
        check("rstm_alu_b",      alu_b,          64'd0);
        check("rstm_alu_cntrl",  64'(alu_cntrl), 64'd0);
        check("rstm_rsp_result", rsp_result,     64'd0);
        check("rstm_rsp_id",     64'(rsp_id),    64'd0);
        check("rstm_rsp_err",    64'(rsp_err),   64'd0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rstm_no_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        set_add(0, 20);
        set_add(1, 20);
        #1;
        check("rstm_first_grant", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        req_valid = '0;
        wait_done("rstm_done", base + 1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
